// File: rtl/cell_hist_accum.sv
// cell_hist_accum: ping-pong 18-bin cell histogram accumulator with a valid/ready drain port
module cell_hist_accum #(
   parameter int MAG_WIDTH   = 16,
   parameter int ACC_WIDTH   = 24,
   parameter int CELL_PIXELS = 64,
   parameter int DELAY       = 1
) (
   input  logic                 aclk,
   input  logic                 arest_n,
   input  logic [4:0]           bin_num,
   input  logic [MAG_WIDTH-1:0] bin_mag,
   input  logic                 bin_num_valid,
   output logic [ACC_WIDTH-1:0] hist_data,
   output logic [4:0]           hist_idx,
   output logic                 hist_valid,
   output logic                 hist_last,
   input  logic                 hist_ready,
   output logic                 in_ready,
   output logic                 drop_err,
   output logic                 bin_err,
   output logic                 sat_err
);
   localparam int PW = $clog2(CELL_PIXELS);
   localparam logic [PW-1:0] PIX_LAST = PW'(CELL_PIXELS - 1);
   localparam logic [ACC_WIDTH-1:0] ACC_MAX = '1;
   typedef enum logic [1:0] {IDLE, ACCUM, FULL, DRAIN} bank_st_t;
   if (ACC_WIDTH < MAG_WIDTH || CELL_PIXELS < 2 || DELAY < 0) begin : g_param_chk
      $error("cell_hist_accum: illegal parameter set");
   end
   bank_st_t             st_q [2];
   bank_st_t             st_d [2];
   logic [ACC_WIDTH-1:0] acc [2][18];
   logic [PW-1:0]        pix_cnt;
   logic [4:0]           rd_ptr, rd_bin, wr_bin;
   logic                 acc_sel, drn_sel, acc_en, bin_ok, cell_close, beat_acc, last_acc, load;
   logic [ACC_WIDTH:0]   sum;
   // s: own state, o: other bank, cl: the accumulating bank closes, la: last beat accepted
   function automatic bank_st_t nxt(input bank_st_t s, input bank_st_t o, input logic cl, input logic la);
      return s == IDLE  ? ((o != ACCUM || cl) ? ACCUM : IDLE) :
             s == ACCUM ? (cl ? (o == IDLE ? DRAIN : FULL) : ACCUM) :
             s == FULL  ? ((o != DRAIN || la) ? DRAIN : FULL) :
                          (la ? IDLE : DRAIN);
   endfunction
   // bank selection, sample acceptance, saturating sum and next bank states
   always_comb begin
      in_ready   = st_q[0] == ACCUM || st_q[1] == ACCUM;
      acc_sel    = st_q[1] == ACCUM;
      drn_sel    = st_q[1] == DRAIN;
      acc_en     = bin_num_valid && in_ready;
      bin_ok     = bin_num <= 5'd17;
      wr_bin     = bin_ok ? bin_num : 5'd0;
      rd_bin     = rd_ptr <= 5'd17 ? rd_ptr : 5'd0;
      cell_close = acc_en && pix_cnt == PIX_LAST;
      beat_acc   = hist_valid && hist_ready;
      last_acc   = beat_acc && hist_last;
      load       = (st_q[0] == DRAIN || st_q[1] == DRAIN) && rd_ptr <= 5'd17 && (!hist_valid || hist_ready);
      sum        = {1'b0, acc[acc_sel][wr_bin]} + (ACC_WIDTH+1)'(bin_mag);
      st_d[0]    = nxt(st_q[0], st_q[1], cell_close, last_acc);
      st_d[1]    = nxt(st_q[1], st_q[0], cell_close, last_acc);
   end
   // bank state registers
   always_ff @(posedge aclk or negedge arest_n)
      if (!arest_n) begin
         st_q[0] <= ACCUM;
         st_q[1] <= IDLE;
      end else begin
         st_q[0] <= st_d[0];
         st_q[1] <= st_d[1];
      end
   // pixel counter of the cell being accumulated
   always_ff @(posedge aclk or negedge arest_n)
      if (!arest_n) pix_cnt <= '0;
      else if (acc_en) pix_cnt <= cell_close ? '0 : pix_cnt + 1'b1;
   // accumulator array: saturating add into the ACCUM bank, clear-on-accept in the DRAIN bank
   always_ff @(posedge aclk or negedge arest_n)
      if (!arest_n) begin
         for (int b = 0; b < 2; b++)
            for (int i = 0; i < 18; i++) acc[b][i] <= '0;
      end else begin
         for (int b = 0; b < 2; b++)
            for (int i = 0; i < 18; i++)
               if (acc_en && bin_ok && acc_sel == b[0] && bin_num == i[4:0])
                  acc[b][i] <= sum[ACC_WIDTH] ? ACC_MAX : sum[ACC_WIDTH-1:0];
               else if (beat_acc && drn_sel == b[0] && hist_idx == i[4:0])
                  acc[b][i] <= '0;
      end
   // drain output register: loads the next bin whenever the current beat is empty or taken
   always_ff @(posedge aclk or negedge arest_n)
      if (!arest_n) begin
         hist_data  <= '0;
         hist_idx   <= '0;
         hist_last  <= 1'b0;
         hist_valid <= 1'b0;
         rd_ptr     <= '0;
      end else begin
         if (load) begin
            hist_data <= acc[drn_sel][rd_bin];
            hist_idx  <= rd_ptr;
            hist_last <= rd_ptr == 5'd17;
            rd_ptr    <= rd_ptr + 5'd1;
         end else if (last_acc) rd_ptr <= '0;
         hist_valid <= load || (hist_valid && !hist_ready);
      end
   // sticky error flags
   always_ff @(posedge aclk or negedge arest_n)
      if (!arest_n) begin
         drop_err <= 1'b0;
         bin_err  <= 1'b0;
         sat_err  <= 1'b0;
      end else begin
         drop_err <= drop_err || (bin_num_valid && !in_ready);
         bin_err  <= bin_err || (acc_en && !bin_ok);
         sat_err  <= sat_err || (acc_en && bin_ok && sum[ACC_WIDTH]);
      end
endmodule

// File: tb/tb_cell_hist_accum.sv
// tb_cell_hist_accum: table-driven and randomized checks of cell_hist_accum against a histogram model
module tb_cell_hist_accum;
   logic        aclk = 0, arest_n = 0, bin_num_valid = 0, hist_ready = 0;
   logic [4:0]  bin_num = 0;
   logic [15:0] bin_mag = 0;
   logic [23:0] hist_data;
   logic [4:0]  hist_idx, d16_idx;
   logic        hist_valid, hist_last, in_ready, drop_err, bin_err, sat_err;
   logic [15:0] d16_data;
   logic        d16_valid, d16_last, d16_in_ready, d16_drop, d16_bin, d16_sat;
   cell_hist_accum #(.MAG_WIDTH(16), .ACC_WIDTH(24), .CELL_PIXELS(64)) dut (
      .aclk(aclk), .arest_n(arest_n), .bin_num(bin_num), .bin_mag(bin_mag), .bin_num_valid(bin_num_valid),
      .hist_data(hist_data), .hist_idx(hist_idx), .hist_valid(hist_valid), .hist_last(hist_last),
      .hist_ready(hist_ready), .in_ready(in_ready), .drop_err(drop_err), .bin_err(bin_err), .sat_err(sat_err));
   cell_hist_accum #(.MAG_WIDTH(16), .ACC_WIDTH(16), .CELL_PIXELS(64)) dut16 (
      .aclk(aclk), .arest_n(arest_n), .bin_num(bin_num), .bin_mag(bin_mag), .bin_num_valid(bin_num_valid),
      .hist_data(d16_data), .hist_idx(d16_idx), .hist_valid(d16_valid), .hist_last(d16_last),
      .hist_ready(hist_ready), .in_ready(d16_in_ready), .drop_err(d16_drop), .bin_err(d16_bin), .sat_err(d16_sat));
   always #5 aclk = ~aclk;
   typedef struct {logic [4:0] idx; logic [23:0] d24; logic [15:0] d16; logic last;} beat_t;
   typedef struct {logic [4:0] bin; logic [15:0] mag; int bad_pix; logic e_bin; logic e_sat16;} row_t;
   beat_t       exp_q [$];
   beat_t       eb;
   row_t        tbl [5];
   logic [4:0]  cb [64];
   logic [15:0] cm [64];
   int          n_chk = 0, n_fail = 0;
   logic        rdy_rand = 0;
   logic        p_v = 0, p_r = 0, p_l = 0;
   logic [4:0]  p_i = 0;
   logic [23:0] p_d = 0;
   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask
   // reference: per-bin totals of the cell, clipped to each accumulator width
   task automatic push_model();
      longint tot [18];
      beat_t  nb;
      for (int i = 0; i < 18; i++) tot[i] = 0;
      for (int p = 0; p < 64; p++) if (cb[p] < 18) tot[cb[p]] += longint'(cm[p]);
      for (int i = 0; i < 18; i++) begin
         nb.idx  = 5'(i);
         nb.d24  = tot[i] > 64'hFFFFFF ? 24'hFFFFFF : tot[i][23:0];
         nb.d16  = tot[i] > 64'hFFFF ? 16'hFFFF : tot[i][15:0];
         nb.last = i == 17;
         exp_q.push_back(nb);
      end
   endtask
   task automatic send_cell(input int gap_pct);
      for (int p = 0; p < 64; p++) begin
         while (gap_pct > 0 && $urandom_range(0, 99) < gap_pct) begin
            @(posedge aclk); #1;
            bin_num_valid = 0;
         end
         @(posedge aclk); #1;
         bin_num = cb[p];
         bin_mag = cm[p];
         bin_num_valid = 1;
      end
      push_model();
   endtask
   task automatic idle();
      @(posedge aclk); #1;
      bin_num_valid = 0;
   endtask
   task automatic wait_empty(input int lim);
      int n = 0;
      while (exp_q.size() != 0 && n < lim) begin
         @(posedge aclk);
         n++;
      end
      chk("drain_complete_beats_left", exp_q.size(), 0);
      repeat (3) @(posedge aclk);
      #1;
   endtask
   always @(posedge aclk) begin
      #1;
      if (rdy_rand) hist_ready = $urandom_range(0, 3) != 0;
   end
   // beat monitor: scoreboard compare on every accepted beat, hold check while stalled
   always @(negedge aclk) begin
      if (arest_n && p_v && !p_r) begin
         chk("hold_valid", hist_valid, 1);
         chk("hold_idx", hist_idx, p_i);
         chk("hold_data", hist_data, p_d);
         chk("hold_last", hist_last, p_l);
      end
      if (arest_n && hist_valid && hist_ready) begin
         if (exp_q.size() == 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL unexpected_beat: got idx %0d expected no beat at %0t", hist_idx, $time);
         end else begin
            eb = exp_q.pop_front();
            chk("beat_idx", hist_idx, eb.idx);
            chk("beat_data", hist_data, eb.d24);
            chk("beat_last", hist_last, eb.last);
            chk("beat16_valid", d16_valid, 1);
            chk("beat16_data", d16_data, eb.d16);
         end
      end
      p_v = arest_n && hist_valid;
      p_r = hist_ready;
      p_i = hist_idx;
      p_d = hist_data;
      p_l = hist_last;
   end
   initial begin
      #400000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end
   initial begin
      int n;
      tbl[0] = '{5'd3,  16'd10,     -1, 1'b0, 1'b0};
      tbl[1] = '{5'd0,  16'd1,      -1, 1'b0, 1'b0};
      tbl[2] = '{5'd17, 16'd2,      -1, 1'b0, 1'b0};
      tbl[3] = '{5'd5,  16'hFFFF,   -1, 1'b0, 1'b1};
      tbl[4] = '{5'd7,  16'd5,       9, 1'b1, 1'b1};
      repeat (3) @(posedge aclk);
      #1;
      chk("rst_valid", hist_valid, 0);
      chk("rst_last", hist_last, 0);
      chk("rst_idx", hist_idx, 0);
      chk("rst_data", hist_data, 0);
      chk("rst_in_ready", in_ready, 1);
      chk("rst_drop", drop_err, 0);
      chk("rst_bin", bin_err, 0);
      chk("rst_sat", sat_err, 0);
      arest_n = 1;
      hist_ready = 1;
      for (int r = 0; r < 5; r++) begin
         for (int p = 0; p < 64; p++) begin
            cb[p] = (p == tbl[r].bad_pix) ? 5'd18 : tbl[r].bin;
            cm[p] = tbl[r].mag;
         end
         send_cell(0);
         @(negedge aclk);
         chk("row_bin_err", bin_err, tbl[r].e_bin);
         chk("row_sat16", d16_sat, tbl[r].e_sat16);
         chk("row_sat24", sat_err, 0);
         chk("row_drop", drop_err, 0);
         chk("row_in_ready", in_ready, 1);
      end
      idle();
      wait_empty(300);
      chk("table_drop", drop_err, 0);
      chk("table_idle_valid", hist_valid, 0);
      rdy_rand = 1;
      for (int c = 0; c < 6; c++) begin
         for (int p = 0; p < 64; p++) begin
            cb[p] = 5'($urandom_range(0, 18));
            cm[p] = 16'($urandom);
         end
         send_cell(25);
      end
      idle();
      wait_empty(600);
      rdy_rand = 0;
      @(posedge aclk); #2;
      hist_ready = 1;
      chk("rand_drop", drop_err, 0);
      chk("rand_sat24", sat_err, 0);
      hist_ready = 0;
      for (int p = 0; p < 64; p++) begin cb[p] = 5'd4; cm[p] = 16'd1; end
      send_cell(0);
      for (int p = 0; p < 64; p++) begin cb[p] = 5'd9; cm[p] = 16'd2; end
      send_cell(0);
      @(posedge aclk); #1;
      chk("t3_in_ready_low", in_ready, 0);
      chk("t3_drop_before", drop_err, 0);
      repeat (134) begin @(posedge aclk); #1; end
      chk("t3_drop_after", drop_err, 1);
      chk("t3_valid_held", hist_valid, 1);
      chk("t3_idx_held", hist_idx, 0);
      chk("t3_data_held", hist_data, 0);
      bin_num_valid = 0;
      hist_ready = 1;
      wait_empty(300);
      chk("t3_in_ready_back", in_ready, 1);
      for (int p = 0; p < 64; p++) begin cb[p] = 5'd3; cm[p] = 16'd10; end
      send_cell(0);
      idle();
      n = 0;
      do begin
         @(negedge aclk);
         n++;
      end while (!(hist_valid && hist_idx == 5'd7) && n < 100);
      chk("t6_reached_idx7", n < 100, 1);
      arest_n = 0;
      #1;
      exp_q.delete();
      chk("t6_valid_async", hist_valid, 0);
      chk("t6_idx_async", hist_idx, 0);
      chk("t6_drop_clr", drop_err, 0);
      chk("t6_bin_clr", bin_err, 0);
      chk("t6_sat16_clr", d16_sat, 0);
      chk("t6_in_ready", in_ready, 1);
      #7;
      arest_n = 1;
      for (int p = 0; p < 64; p++) begin cb[p] = 5'd11; cm[p] = 16'd7; end
      send_cell(0);
      idle();
      wait_empty(300);
      chk("final_valid", hist_valid, 0);
      chk("final_bin_err", bin_err, 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
